fetch_stage: RTL and testbench

//  Instruction-fetch stage directly downstream of the program counter. Takes the

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/fetch_skid_buf.sv | 56 +++++
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: IF/ID register layout, the NOP encoding and the
// fetch-stage FSM states.
package pipe_pkg;

   localparam int PIPE_XLEN = 32;

   localparam logic [PIPE_XLEN-1:0] NOP_INSTR = 32'h0000_0000;

   // IF/ID pipeline register contents
   typedef struct packed {
      logic                 valid;
      logic [PIPE_XLEN-1:0] pc;
      logic [PIPE_XLEN-1:0] pc_plus1;
      logic [PIPE_XLEN-1:0] instr;
   } ifid_t;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HOLD = 1'b1
   } fetch_state_e;

   // Builds an IF/ID entry; pc_plus1 wraps modulo 2^PIPE_XLEN by construction
   function automatic ifid_t make_ifid(input logic                 v,
                                       input logic [PIPE_XLEN-1:0] pc,
                                       input logic [PIPE_XLEN-1:0] instr);
      ifid_t e;
      e.valid    = v;
      e.pc       = pc;
      e.pc_plus1 = pc + {{(PIPE_XLEN-1){1'b0}}, 1'b1};
      e.instr    = instr;
      return e;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer: captures the fetch that was in flight when a stall
// hit, holds it through the stall, and is emptied by a pop or a flush.
module fetch_skid_buf
   import pipe_pkg::*;
#(
   parameter int               XLEN = PIPE_XLEN,
   parameter logic [XLEN-1:0]  NOP  = NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_cap,
   input  logic            i_clr,
   input  logic            i_pop,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_instr,
   output logic            o_v,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_instr
);

   logic            r_v;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_instr;

   // Valid flag: clear/pop win over capture; a full entry is never overwritten
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v <= 1'b0;
      end else if (i_clr || i_pop) begin
         r_v <= 1'b0;
      end else if (i_cap && !r_v) begin
         r_v <= 1'b1;
      end else begin
         r_v <= r_v;
      end
   end

   // Payload: loaded only when a capture actually fills an empty entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc    <= {XLEN{1'b0}};
         r_instr <= NOP;
      end else if (i_cap && !r_v && !i_clr && !i_pop) begin
         r_pc    <= i_pc;
         r_instr <= i_instr;
      end else begin
         r_pc    <= r_pc;
         r_instr <= r_instr;
      end
   end

   assign o_v     = r_v;
   assign o_pc    = r_pc;
   assign o_instr = r_instr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the 1-cycle synchronous imem from the PC,
// tracks the outstanding read, and loads the IF/ID register. Stalls are
// absorbed by a one-entry skid buffer; flushes kill wrong-path fetches.
module fetch_stage
   import pipe_pkg::*;
#(
   parameter int               XLEN = PIPE_XLEN,
   parameter int               AW   = 10,
   parameter logic [XLEN-1:0]  NOP  = NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_stall,
   input  logic            i_flush,
   output logic            o_imem_req,
   output logic [AW-1:0]   o_imem_addr,
   input  logic [XLEN-1:0] i_imem_rdata,
   output logic            o_pc_hold,
   output logic            o_ifid_valid,
   output logic [XLEN-1:0] o_ifid_pc,
   output logic [XLEN-1:0] o_ifid_pc_plus1,
   output logic [XLEN-1:0] o_ifid_instr
);

   fetch_state_e    r_state;
   fetch_state_e    w_state_nxt;
   logic            r_inflight_v;
   logic [XLEN-1:0] r_inflight_pc;
   ifid_t           r_ifid;
   ifid_t           w_ifid_nxt;
   logic            w_req;
   logic            w_skid_cap;
   logic            w_skid_clr;
   logic            w_skid_pop;
   logic            w_skid_v;
   logic [XLEN-1:0] w_skid_pc;
   logic [XLEN-1:0] w_skid_instr;

   // A stalled or flushed cycle never issues a read; flush releases the PC so
   // it can load the branch target even if the hazard unit is stalling.
   assign w_req       = !i_stall && !i_flush;
   assign o_imem_req  = w_req;
   assign o_pc_hold   = i_stall && !i_flush;
   assign o_imem_addr = i_pc[AW-1:0];

   fetch_skid_buf #(
      .XLEN (XLEN),
      .NOP  (NOP)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_cap   (w_skid_cap),
      .i_clr   (w_skid_clr),
      .i_pop   (w_skid_pop),
      .i_pc    (r_inflight_pc),
      .i_instr (i_imem_rdata),
      .o_v     (w_skid_v),
      .o_pc    (w_skid_pc),
      .o_instr (w_skid_instr)
   );

   // In-flight tracker: remembers which PC the data arriving next cycle belongs to
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight_v  <= 1'b0;
         r_inflight_pc <= {XLEN{1'b0}};
      end else begin
         r_inflight_v  <= w_req;
         r_inflight_pc <= i_pc;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: flush always returns to RUN, otherwise stall selects HOLD
   always_comb begin
      w_state_nxt = r_state;
      if (i_flush) begin
         w_state_nxt = RUN;
      end else begin
         case (r_state)
            RUN:     w_state_nxt = i_stall ? HOLD : RUN;
            HOLD:    w_state_nxt = i_stall ? HOLD : RUN;
            default: w_state_nxt = RUN;
         endcase
      end
   end

   // FSM outputs: next IF/ID contents and skid buffer control
   always_comb begin
      w_ifid_nxt = r_ifid;
      w_skid_cap = 1'b0;
      w_skid_clr = 1'b0;
      w_skid_pop = 1'b0;
      if (i_flush) begin
         w_ifid_nxt.valid = 1'b0;
         w_ifid_nxt.instr = NOP;
         w_skid_clr       = 1'b1;
      end else begin
         case (r_state)
            RUN: begin
               if (i_stall) begin
                  // Park the returning word; IF/ID stays frozen
                  w_skid_cap = r_inflight_v;
               end else begin
                  w_ifid_nxt = make_ifid(r_inflight_v, r_inflight_pc,
                                         r_inflight_v ? i_imem_rdata : NOP);
               end
            end
            HOLD: begin
               if (i_stall) begin
                  w_ifid_nxt = r_ifid;
               end else begin
                  // Drain the skid entry while the held PC's read goes out
                  w_ifid_nxt = make_ifid(w_skid_v, w_skid_pc,
                                         w_skid_v ? w_skid_instr : NOP);
                  w_skid_pop = 1'b1;
               end
            end
            default: begin
               w_ifid_nxt = r_ifid;
            end
         endcase
      end
   end

   // IF/ID pipeline register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ifid.valid    <= 1'b0;
         r_ifid.pc       <= {XLEN{1'b0}};
         r_ifid.pc_plus1 <= {{(XLEN-1){1'b0}}, 1'b1};
         r_ifid.instr    <= NOP;
      end else begin
         r_ifid <= w_ifid_nxt;
      end
   end

   assign o_ifid_valid    = r_ifid.valid;
   assign o_ifid_pc       = r_ifid.pc;
   assign o_ifid_pc_plus1 = r_ifid.pc_plus1;
   assign o_ifid_instr    = r_ifid.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. The bench plays the program
// counter (advance unless held, load target on flush) and a 1-cycle imem
// whose word k is 32'hA000_0000 + k.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        stall;
   logic        flush;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        pc_hold;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc_plus1;
   logic [31:0] ifid_instr;

   int total = 0;
   int bad   = 0;

   fetch_stage dut (
      .clk             (clk),
      .rst             (rst),
      .i_pc            (pc),
      .i_stall         (stall),
      .i_flush         (flush),
      .o_imem_req      (imem_req),
      .o_imem_addr     (imem_addr),
      .i_imem_rdata    (imem_rdata),
      .o_pc_hold       (pc_hold),
      .o_ifid_valid    (ifid_valid),
      .o_ifid_pc       (ifid_pc),
      .o_ifid_pc_plus1 (ifid_pc_plus1),
      .o_ifid_instr    (ifid_instr)
   );

   always #5 clk = ~clk;

   // imem model: 1-cycle read latency
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= 32'hA000_0000 + {22'd0, imem_addr};
   end

   // One clock with the given controls; PC model updated just after the edge
   task automatic step(input logic s, input logic f, input logic [31:0] tgt);
      stall = s;
      flush = f;
      @(posedge clk);
      #1;
      if (f) pc = tgt;
      else if (!s) pc = pc + 32'd1;
      stall = 1'b0;
      flush = 1'b0;
      #1;
   endtask

   task automatic apply_reset();
      rst   = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      pc    = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [96:0] got, want;
      rst = 1'b1; stall = 1'b0; flush = 1'b0; pc = 32'd0;
      #1;
      got  = {ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr};
      want = {1'b0, 32'd0, 32'd1, 32'h0};
      total++;
      if (got !== want) begin bad++; $display("FAIL reset_ifid: got %h want %h", got, want); end
      total++;
      if ({imem_req, pc_hold} !== 2'b10) begin
         bad++; $display("FAIL reset_comb: got %b want 10", {imem_req, pc_hold});
      end
   endtask

   task automatic test_free_run();
      logic [96:0] got, want;
      apply_reset();
      step(1'b0, 1'b0, 32'd0);
      total++;
      if ({ifid_valid, ifid_instr} !== {1'b0, 32'h0}) begin
         bad++; $display("FAIL run_edge1: got %h want %h", {ifid_valid, ifid_instr}, {1'b0, 32'h0});
      end
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b0, 32'd0);
         got  = {ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr};
         want = {1'b1, 32'(k), 32'(k + 1), 32'hA000_0000 + 32'(k)};
         total++;
         if (got !== want) begin bad++; $display("FAIL run_k%0d: got %h want %h", k, got, want); end
      end
   endtask

   task automatic test_stall();
      logic [96:0] got, want;
      apply_reset();
      repeat (6) step(1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         stall = 1'b1;
         #1;
         total++;
         if ({imem_req, pc_hold} !== 2'b01) begin
            bad++; $display("FAIL stall_comb%0d: got %b want 01", i, {imem_req, pc_hold});
         end
         step(1'b1, 1'b0, 32'd0);
         got  = {ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr};
         want = {1'b1, 32'd4, 32'd5, 32'hA000_0004};
         total++;
         if (got !== want) begin bad++; $display("FAIL stall_hold%0d: got %h want %h", i, got, want); end
      end
      for (int k = 5; k < 8; k++) begin
         step(1'b0, 1'b0, 32'd0);
         got  = {ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr};
         want = {1'b1, 32'(k), 32'(k + 1), 32'hA000_0000 + 32'(k)};
         total++;
         if (got !== want) begin bad++; $display("FAIL stall_release_pc%0d: got %h want %h", k, got, want); end
      end
   endtask

   task automatic test_flush();
      logic [96:0] got, want;
      apply_reset();
      repeat (8) step(1'b0, 1'b0, 32'd0);
      flush = 1'b1;
      #1;
      total++;
      if ({imem_req, pc_hold} !== 2'b00) begin
         bad++; $display("FAIL flush_comb: got %b want 00", {imem_req, pc_hold});
      end
      step(1'b0, 1'b1, 32'd20);
      for (int i = 0; i < 2; i++) begin
         total++;
         if ({ifid_valid, ifid_instr} !== {1'b0, 32'h0}) begin
            bad++; $display("FAIL flush_bubble%0d: got %h want %h", i, {ifid_valid, ifid_instr}, {1'b0, 32'h0});
         end
         step(1'b0, 1'b0, 32'd0);
      end
      for (int k = 20; k < 22; k++) begin
         got  = {ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr};
         want = {1'b1, 32'(k), 32'(k + 1), 32'hA000_0000 + 32'(k)};
         total++;
         if (got !== want) begin bad++; $display("FAIL flush_target%0d: got %h want %h", k, got, want); end
         step(1'b0, 1'b0, 32'd0);
      end
   endtask

   task automatic test_stall_flush();
      logic [96:0] got, want;
      apply_reset();
      repeat (6) step(1'b0, 1'b0, 32'd0);
      stall = 1'b1; flush = 1'b1;
      #1;
      total++;
      if ({imem_req, pc_hold} !== 2'b00) begin
         bad++; $display("FAIL sf_comb: got %b want 00", {imem_req, pc_hold});
      end
      step(1'b1, 1'b1, 32'd30);
      step(1'b0, 1'b0, 32'd0);
      total++;
      if ({ifid_valid, ifid_instr} !== {1'b0, 32'h0}) begin
         bad++; $display("FAIL sf_bubble: got %h want %h", {ifid_valid, ifid_instr}, {1'b0, 32'h0});
      end
      step(1'b0, 1'b0, 32'd0);
      got  = {ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr};
      want = {1'b1, 32'd30, 32'd31, 32'hA000_001E};
      total++;
      if (got !== want) begin bad++; $display("FAIL sf_target: got %h want %h", got, want); end
      // Enter HOLD with pc 31 parked in the skid buffer, then flush
      step(1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'd0);
      stall = 1'b1; flush = 1'b1;
      #1;
      total++;
      if (pc_hold !== 1'b0) begin bad++; $display("FAIL hold_flush_pc_hold: got %b want 0", pc_hold); end
      step(1'b1, 1'b1, 32'd50);
      for (int i = 0; i < 2; i++) begin
         total++;
         if ({ifid_valid, ifid_instr} !== {1'b0, 32'h0}) begin
            bad++; $display("FAIL hold_flush_bubble%0d: got %h want %h", i, {ifid_valid, ifid_instr}, {1'b0, 32'h0});
         end
         step(1'b0, 1'b0, 32'd0);
      end
      for (int k = 50; k < 52; k++) begin
         got  = {ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr};
         want = {1'b1, 32'(k), 32'(k + 1), 32'hA000_0000 + 32'(k)};
         total++;
         if (got !== want) begin bad++; $display("FAIL hold_flush_target%0d: got %h want %h", k, got, want); end
         step(1'b0, 1'b0, 32'd0);
      end
   endtask

   task automatic test_wrap();
      logic [96:0] got, want;
      apply_reset();
      step(1'b0, 1'b1, 32'hFFFF_FFFF);
      total++;
      if (imem_addr !== 10'h3FF) begin bad++; $display("FAIL wrap_addr: got %h want 3ff", imem_addr); end
      step(1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 32'd0);
      got  = {ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr};
      want = {1'b1, 32'hFFFF_FFFF, 32'd0, 32'hA000_03FF};
      total++;
      if (got !== want) begin bad++; $display("FAIL wrap_ifid: got %h want %h", got, want); end
      step(1'b0, 1'b0, 32'd0);
      got  = {ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr};
      want = {1'b1, 32'd0, 32'd1, 32'hA000_0000};
      total++;
      if (got !== want) begin bad++; $display("FAIL wrap_next: got %h want %h", got, want); end
   endtask

   task automatic test_reset_mid_hold();
      logic [96:0] got, want;
      apply_reset();
      repeat (6) step(1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'd0);
      stall = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      got  = {ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr};
      want = {1'b0, 32'd0, 32'd1, 32'h0};
      total++;
      if (got !== want) begin bad++; $display("FAIL async_rst_ifid: got %h want %h", got, want); end
      stall = 1'b0;
      pc    = 32'd0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b0, 32'd0);
      total++;
      if ({ifid_valid, ifid_instr} !== {1'b0, 32'h0}) begin
         bad++; $display("FAIL rst_restart_bubble: got %h want %h", {ifid_valid, ifid_instr}, {1'b0, 32'h0});
      end
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b0, 32'd0);
         got  = {ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr};
         want = {1'b1, 32'(k), 32'(k + 1), 32'hA000_0000 + 32'(k)};
         total++;
         if (got !== want) begin bad++; $display("FAIL rst_restart%0d: got %h want %h", k, got, want); end
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_flush();
      test_stall_flush();
      test_wrap();
      test_reset_mid_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
